// File: rtl/ternary_neuron_accum.sv
// Ternary neuron back-end: accumulates saturated (pos - neg) popcount
// differences over N_CHUNKS beats, then presents sum and activation.
module ternary_neuron_accum #(
  parameter int PC_W     = 5,
  parameter int N_CHUNKS = 4,
  parameter int ACC_W    = 8,
  parameter logic signed [ACC_W-1:0] THRESH = '0
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    in_valid,
  output logic                    in_ready,
  input  logic [PC_W-1:0]         pc_pos,
  input  logic [PC_W-1:0]         pc_neg,
  output logic                    out_valid,
  input  logic                    out_ready,
  output logic signed [ACC_W-1:0] out_sum,
  output logic                    out_act
);

  localparam int CNT_W = (N_CHUNKS > 1) ? $clog2(N_CHUNKS) : 1;
  localparam logic [CNT_W-1:0] LAST = CNT_W'(N_CHUNKS - 1);
  localparam int EXT = ACC_W + 1 - PC_W;

  localparam logic signed [ACC_W:0] MAX =
    {2'b00, {(ACC_W-1){1'b1}}};
  localparam logic signed [ACC_W:0] MIN =
    {2'b11, {(ACC_W-1){1'b0}}};

  typedef enum logic {
    S_ACC,
    S_OUT
  } state_t;

  state_t                  state_q;
  logic signed [ACC_W-1:0] acc_q;
  logic signed [ACC_W-1:0] acc_d;
  logic [CNT_W-1:0]        cnt_q;
  logic signed [ACC_W-1:0] sum_q;
  logic                    act_q;

  logic signed [ACC_W:0] diff;
  logic signed [ACC_W:0] sum_w;
  logic                  act_d;

  // Headroom: one extra bit holds any acc + diff without wrap.
  always_comb begin
    diff = $signed({{EXT{1'b0}}, pc_pos})
         - $signed({{EXT{1'b0}}, pc_neg});
    sum_w = $signed({acc_q[ACC_W-1], acc_q}) + diff;
    if (sum_w > MAX) begin
      acc_d = MAX[ACC_W-1:0];
    end else if (sum_w < MIN) begin
      acc_d = MIN[ACC_W-1:0];
    end else begin
      acc_d = sum_w[ACC_W-1:0];
    end
    act_d = (acc_d >= THRESH);
  end

  assign in_ready  = (state_q == S_ACC) & ~rst;
  assign out_valid = (state_q == S_OUT);
  assign out_sum   = sum_q;
  assign out_act   = act_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_ACC;
      acc_q   <= '0;
      cnt_q   <= '0;
      sum_q   <= '0;
      act_q   <= 1'b0;
    end else begin
      unique case (state_q)
        S_ACC: begin
          if (in_valid) begin
            if (cnt_q == LAST) begin
              sum_q   <= acc_d;
              act_q   <= act_d;
              acc_q   <= '0;
              cnt_q   <= '0;
              state_q <= S_OUT;
            end else begin
              acc_q <= acc_d;
              cnt_q <= cnt_q + 1'b1;
            end
          end
        end
        S_OUT: begin
          if (out_ready) begin
            state_q <= S_ACC;
          end
        end
        default: state_q <= S_ACC;
      endcase
    end
  end

endmodule

// File: tb/tb_ternary_neuron_accum.sv
// Directed bench for ternary_neuron_accum: three parameterisations
// share stimulus; only the selected instance is checked per test.
module tb_ternary_neuron_accum;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       in_valid = 1'b0;
  logic       out_ready = 1'b1;
  logic [4:0] pc_pos = '0;
  logic [4:0] pc_neg = '0;

  logic       rdy0, rdy1, rdy2;
  logic       vld0, vld1, vld2;
  logic       act0, act1, act2;
  logic signed [7:0] sum0;
  logic signed [5:0] sum1;
  logic signed [7:0] sum2;

  int sel = 0;
  int errors = 0;
  int checks = 0;

  int c_rdy, c_vld, c_sum, c_act;

  always #5 clk = ~clk;

  ternary_neuron_accum #(
    .PC_W(5), .N_CHUNKS(4), .ACC_W(8), .THRESH(8'sd0)
  ) u_n4w8 (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_ready(rdy0),
    .pc_pos(pc_pos), .pc_neg(pc_neg),
    .out_valid(vld0), .out_ready(out_ready),
    .out_sum(sum0), .out_act(act0)
  );

  ternary_neuron_accum #(
    .PC_W(5), .N_CHUNKS(4), .ACC_W(6), .THRESH(6'sd0)
  ) u_n4w6 (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_ready(rdy1),
    .pc_pos(pc_pos), .pc_neg(pc_neg),
    .out_valid(vld1), .out_ready(out_ready),
    .out_sum(sum1), .out_act(act1)
  );

  ternary_neuron_accum #(
    .PC_W(5), .N_CHUNKS(1), .ACC_W(8), .THRESH(8'sd0)
  ) u_n1w8 (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_ready(rdy2),
    .pc_pos(pc_pos), .pc_neg(pc_neg),
    .out_valid(vld2), .out_ready(out_ready),
    .out_sum(sum2), .out_act(act2)
  );

  always_comb begin
    c_rdy = int'(rdy0);
    c_vld = int'(vld0);
    c_sum = int'(sum0);
    c_act = int'(act0);
    if (sel == 1) begin
      c_rdy = int'(rdy1);
      c_vld = int'(vld1);
      c_sum = int'(sum1);
      c_act = int'(act1);
    end else if (sel == 2) begin
      c_rdy = int'(rdy2);
      c_vld = int'(vld2);
      c_sum = int'(sum2);
      c_act = int'(act2);
    end
  end

  typedef struct {
    string name;
    int    sel;
    int    n;
    int    pos[4];
    int    neg[4];
    int    esum;
    int    eact;
  } vec_t;

  vec_t vecs[7];

  task automatic chk(input string nm, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset(input string nm);
    rst = 1'b1;
    in_valid = 1'b0;
    tick();
    chk({nm, ".rst_ready"}, c_rdy, 0);
    chk({nm, ".rst_valid"}, c_vld, 0);
    chk({nm, ".rst_sum"}, c_sum, 0);
    chk({nm, ".rst_act"}, c_act, 0);
    rst = 1'b0;
    #1;
  endtask

  task automatic beat(input int p, input int n);
    in_valid = 1'b1;
    pc_pos = 5'(p);
    pc_neg = 5'(n);
    tick();
    in_valid = 1'b0;
  endtask

  task automatic run_vec(input vec_t v);
    sel = v.sel;
    out_ready = 1'b1;
    do_reset(v.name);
    for (int i = 0; i < v.n; i++) begin
      chk({v.name, ".ready"}, c_rdy, 1);
      chk({v.name, ".early_valid"}, c_vld, 0);
      beat(v.pos[i], v.neg[i]);
    end
    chk({v.name, ".valid"}, c_vld, 1);
    chk({v.name, ".sum"}, c_sum, v.esum);
    chk({v.name, ".act"}, c_act, v.eact);
    chk({v.name, ".out_ready_low"}, c_rdy, 0);
    tick();
    chk({v.name, ".valid_drop"}, c_vld, 0);
    chk({v.name, ".ready_back"}, c_rdy, 1);
  endtask

  initial begin
    vecs[0] = '{"basic", 0, 4, '{5, 3, 0, 10}, '{2, 3, 4, 1}, 8, 1};
    vecs[1] = '{"neg80", 0, 4, '{0, 0, 0, 0}, '{20, 20, 20, 20}, -80, 0};
    vecs[2] = '{"thr_eq", 0, 4, '{1, 1, 1, 1}, '{1, 1, 1, 1}, 0, 1};
    vecs[3] = '{"pos124", 0, 4, '{31, 31, 31, 31}, '{0, 0, 0, 0}, 124, 1};
    vecs[4] = '{"sat_hi", 1, 4, '{31, 31, 31, 31}, '{0, 0, 0, 0}, 31, 1};
    vecs[5] = '{"sat_lo", 1, 4, '{0, 0, 0, 0}, '{31, 31, 31, 31}, -32, 0};
    vecs[6] = '{"n1_one", 2, 1, '{7, 0, 0, 0}, '{3, 0, 0, 0}, 4, 1};

    repeat (2) tick();

    for (int k = 0; k < 7; k++) begin
      run_vec(vecs[k]);
    end

    // Bubbles between beats, then a stalled result with new data offered.
    begin
      int bp[4];
      int bn[4];
      bp = '{5, 3, 0, 10};
      bn = '{2, 3, 4, 1};
      sel = 0;
      out_ready = 1'b0;
      do_reset("bub");
      for (int i = 0; i < 4; i++) begin
        beat(bp[i], bn[i]);
        if (i < 3) begin
          for (int j = 0; j < 3; j++) begin
            pc_pos = 5'd31;
            pc_neg = 5'd0;
            tick();
            chk("bub.idle_ready", c_rdy, 1);
            chk("bub.idle_valid", c_vld, 0);
          end
        end
      end
      chk("bub.valid", c_vld, 1);
      chk("bub.sum", c_sum, 8);
      for (int k = 0; k < 5; k++) begin
        in_valid = 1'b1;
        pc_pos = 5'd31;
        pc_neg = 5'd0;
        tick();
        chk("stall.valid", c_vld, 1);
        chk("stall.sum", c_sum, 8);
        chk("stall.act", c_act, 1);
        chk("stall.ready", c_rdy, 0);
      end
      out_ready = 1'b1;
      tick();
      in_valid = 1'b0;
      chk("stall.release_valid", c_vld, 0);
      chk("stall.release_ready", c_rdy, 1);
      for (int i = 0; i < 4; i++) begin
        beat(1, 0);
      end
      chk("after.valid", c_vld, 1);
      chk("after.sum", c_sum, 4);
      chk("after.act", c_act, 1);
      tick();
    end

    // Abort a partial evaluation with reset.
    begin
      sel = 0;
      out_ready = 1'b1;
      do_reset("abort_pre");
      beat(9, 0);
      beat(9, 0);
      chk("abort.no_valid", c_vld, 0);
      do_reset("abort");
      for (int i = 0; i < 4; i++) begin
        chk("abort.pre_valid", c_vld, 0);
        beat(0, 2);
      end
      chk("abort.valid", c_vld, 1);
      chk("abort.sum", c_sum, -8);
      chk("abort.act", c_act, 0);
      tick();
    end

    // Single-beat evaluations with the source holding its next beat.
    begin
      sel = 2;
      out_ready = 1'b1;
      do_reset("n1");
      in_valid = 1'b1;
      pc_pos = 5'd7;
      pc_neg = 5'd3;
      tick();
      chk("n1.r1_valid", c_vld, 1);
      chk("n1.r1_sum", c_sum, 4);
      chk("n1.r1_act", c_act, 1);
      chk("n1.r1_ready", c_rdy, 0);
      pc_pos = 5'd2;
      pc_neg = 5'd6;
      tick();
      chk("n1.gap_valid", c_vld, 0);
      chk("n1.gap_ready", c_rdy, 1);
      tick();
      in_valid = 1'b0;
      chk("n1.r2_valid", c_vld, 1);
      chk("n1.r2_sum", c_sum, -4);
      chk("n1.r2_act", c_act, 0);
      chk("n1.r2_ready", c_rdy, 0);
      tick();
      chk("n1.end_valid", c_vld, 0);
      chk("n1.end_ready", c_rdy, 1);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
